// File: rtl/soc_tick_cap_pkg.sv
// Shared register map, CSR bit positions and EVT word layout for the tick capture block.
package soc_tick_cap_pkg;

  localparam logic [3:0] AddrCsr = 4'h0;
  localparam logic [3:0] AddrNow = 4'h1;
  localparam logic [3:0] AddrEvt = 4'h2;
  localparam int unsigned AddrCntBase = 4;

  localparam int unsigned CsrEnBit  = 0;
  localparam int unsigned CsrClrBit = 1;
  localparam int unsigned CsrOvfBit = 2;
  localparam int unsigned CsrLvlLsb = 8;
  localparam int unsigned CsrLvlW   = 8;

  localparam int unsigned EvtValidBit = 31;
  localparam int unsigned EvtSrcLsb   = 24;
  localparam int unsigned EvtSrcW     = 4;

  // Timestamp arrives zero-extended to 24 bits so the helper is width-independent.
  function automatic logic [31:0] evt_word(logic [EvtSrcW-1:0] src, logic [23:0] ts);
    logic [31:0] w;
    w = 32'(ts);
    w[EvtSrcLsb +: EvtSrcW] = src;
    w[EvtValidBit] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/soc_tick_cap_if.sv
// Register bus between a host and soc_tick_cap: two-cycle transfers, one-cycle ack.
interface soc_tick_cap_if;
  logic [3:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_wmsk;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/soc_tick_cap_fifo.sv
// Synchronous event FIFO with level and full/empty flags; storage itself is not reset.
module soc_tick_cap_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [AddrW:0]   level_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned Depth = 2 ** AddrW;
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = level_o[AddrW];
  assign pop_ok  = pop_i & ~empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a concurrent push.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PtrOne;
      if (pop_ok)  rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/soc_tick_cap.sv
// Timestamps single-cycle tick strobes into an event FIFO readable over a small register bus.
// Per-source tick counters exist only when SOC_TICK_CAP_COUNTERS_EN is defined.
module soc_tick_cap
  import soc_tick_cap_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned TSW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  tick,
  soc_tick_cap_if.slave wb
);
  localparam int unsigned FifoW = EvtSrcW + TSW;
  localparam logic [TSW-1:0] NowOne = {{(TSW-1){1'b0}}, 1'b1};

  logic                  ack_q, ack_d, en_q, en_d, ovf_q, ovf_d;
  logic [TSW-1:0]        now_q, now_d;
  logic [N-1:0]          pend_q, pend_d;
  logic [N-1:0][TSW-1:0] ts_q, ts_d;

  logic               bus_wr, bus_rd, csr_wr, fifo_clr, pop, push_ok, found;
  logic [N-1:0]       tick_en, tick_cap, grant;
  logic [EvtSrcW-1:0] grant_src;
  logic [TSW-1:0]     grant_ts;
  logic [FifoW-1:0]   head;
  logic [FIFO_AW:0]   level;
  logic               full, empty;
  logic [31:0]        rdata, cnt_rdata;
  logic               unused_bits;

  // Side effects fire only in the ack cycle, once per transfer.
  assign ack_d    = wb.wb_cyc & ~ack_q;
  assign bus_wr   = ack_q & wb.wb_we;
  assign bus_rd   = ack_q & ~wb.wb_we;
  assign csr_wr   = bus_wr & (wb.wb_addr == AddrCsr);
  assign fifo_clr = csr_wr & wb.wb_wdata[CsrClrBit];
  assign pop      = bus_rd & (wb.wb_addr == AddrEvt);
  assign tick_en  = tick & {N{en_q}};
  assign tick_cap = tick_en & ~{N{fifo_clr}};
  assign unused_bits = ^{wb.wb_wdata[31:3], wb.wb_wmsk[3:1]};

  always_comb begin
    grant     = '0;
    grant_src = '0;
    grant_ts  = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_q[i] && !found) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_src = EvtSrcW'(i);
        grant_ts  = ts_q[i];
      end
    end
  end

  assign push_ok = found & ~fifo_clr & (~full | (pop & ~empty));

  always_comb begin
    en_d   = en_q;
    ovf_d  = ovf_q;
    now_d  = now_q + NowOne;
    pend_d = pend_q;
    ts_d   = ts_q;
    if (csr_wr) begin
      if (wb.wb_wmsk[0]) en_d = wb.wb_wdata[CsrEnBit];
      if (wb.wb_wdata[CsrOvfBit]) ovf_d = 1'b0;
    end
    if (push_ok) pend_d = pend_q & ~grant;
    // A tick on a still-pending source is lost; a new overflow beats a same-cycle W1C.
    for (int unsigned i = 0; i < N; i++) begin
      if (tick_cap[i]) begin
        if (pend_q[i]) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          ts_d[i]   = now_q;
        end
      end
    end
    if (fifo_clr) pend_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      en_q   <= 1'b0;
      ovf_q  <= 1'b0;
      now_q  <= '0;
      pend_q <= '0;
      ts_q   <= '0;
    end else begin
      ack_q  <= ack_d;
      en_q   <= en_d;
      ovf_q  <= ovf_d;
      now_q  <= now_d;
      pend_q <= pend_d;
      ts_q   <= ts_d;
    end
  end

  soc_tick_cap_fifo #(
    .Width (FifoW),
    .AddrW (FIFO_AW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (fifo_clr),
    .push_i  (push_ok),
    .wdata_i ({grant_src, grant_ts}),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef SOC_TICK_CAP_COUNTERS_EN
  logic [N-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    cnt_rdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(wb.wb_addr) == AddrCntBase + i) cnt_rdata = 32'(cnt_q[i]);
      // Clear-write wins over a same-cycle tick.
      if (bus_wr && (32'(wb.wb_addr) == AddrCntBase + i)) begin
        cnt_d[i] = '0;
      end else if (tick_en[i] && (cnt_q[i] != 16'hffff)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign cnt_rdata = '0;
`endif

  always_comb begin
    rdata = '0;
    if (ack_q) begin
      case (wb.wb_addr)
        AddrCsr: begin
          rdata[CsrEnBit]                = en_q;
          rdata[CsrOvfBit]               = ovf_q;
          rdata[CsrLvlLsb +: CsrLvlW]    = CsrLvlW'(level);
        end
        AddrNow: rdata = 32'(now_q);
        AddrEvt: if (!empty) rdata = evt_word(head[TSW +: EvtSrcW], 24'(head[TSW-1:0]));
        default: rdata = cnt_rdata;
      endcase
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_rdata = rdata;

endmodule
